// File: rtl/jtopl_pkg.sv
// Shared constants and width helpers for the OPL operator pipeline.
// Width functions are used by port declarations, so they must stay constant-foldable.
package jtopl_pkg;

    localparam int OPL2_GROUPS  = 3;
    localparam int OPL_SUBSLOTS = 6;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int gw_of(input int groups);
        return max1(clog2(groups));
    endfunction

    function automatic int sw_of(input int subslots);
        return max1(clog2(subslots));
    endfunction

    function automatic int iw_of(input int groups, input int subslots);
        return max1(clog2(groups * subslots));
    endfunction

    // A single-channel part would otherwise get a zero-width channel bus.
    function automatic int cw_of(input int groups, input int subslots);
        return max1(clog2((groups * subslots) / 2));
    endfunction

endpackage

// File: rtl/jtopl_slot_seq.sv
// Operator slot sequencer: walks GROUPS x SUBSLOTS slots per sample frame,
// presenting the active slot as group/subslot, one-hot, binary and channel.
module jtopl_slot_seq
    import jtopl_pkg::*;
#(
    parameter int GROUPS   = OPL2_GROUPS,
    parameter int SUBSLOTS = OPL_SUBSLOTS,
    parameter int FRAME_W  = 4
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cen,
    output logic                                 zero,
    output logic                                 last,
    output logic [gw_of(GROUPS)-1:0]             group,
    output logic [sw_of(SUBSLOTS)-1:0]           subslot,
    output logic                                 op,
    output logic [GROUPS*SUBSLOTS-1:0]           slot,
    output logic [iw_of(GROUPS, SUBSLOTS)-1:0]   slot_idx,
    output logic [cw_of(GROUPS, SUBSLOTS)-1:0]   ch,
    output logic [FRAME_W-1:0]                   frame,
    output logic                                 frame_tick
);

    localparam int NSLOT = GROUPS * SUBSLOTS;
    localparam int HALF  = SUBSLOTS / 2;
    localparam int GW    = gw_of(GROUPS);
    localparam int SW    = sw_of(SUBSLOTS);
    localparam int IW    = iw_of(GROUPS, SUBSLOTS);
    localparam int CW    = cw_of(GROUPS, SUBSLOTS);

    localparam logic [NSLOT-1:0] SLOT0 = {{(NSLOT-1){1'b0}}, 1'b1};

    if (SUBSLOTS < 2 || (SUBSLOTS % 2) != 0) begin : g_bad_subslots
        $error("jtopl_slot_seq: SUBSLOTS must be even and at least 2");
    end

    if (GROUPS < 1) begin : g_bad_groups
        $error("jtopl_slot_seq: GROUPS must be at least 1");
    end

    logic             wrap;
    logic [SW-1:0]    sub_nx;
    logic [GW-1:0]    grp_nx;
    logic [NSLOT-1:0] slot_nx;
    logic [IW-1:0]    idx_nx;
    logic [CW-1:0]    ch_nx;
    logic             op_nx;

    always_comb begin
        wrap   = slot_idx == IW'(NSLOT - 1);
        sub_nx = subslot + 1'b1;
        grp_nx = group;
        if (subslot == SW'(SUBSLOTS - 1)) begin
            sub_nx = '0;
            grp_nx = (group == GW'(GROUPS - 1)) ? '0 : group + 1'b1;
        end
        idx_nx = wrap ? '0 : slot_idx + 1'b1;
        op_nx  = sub_nx >= SW'(HALF);
        ch_nx  = CW'(int'(grp_nx) * HALF + int'(sub_nx) % HALF);
        // Reload at slot 0 so a corrupted one-hot never survives a frame.
        if (grp_nx == '0 && sub_nx == '0)
            slot_nx = SLOT0;
        else
            slot_nx = {slot[NSLOT-2:0], slot[NSLOT-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            group      <= '0;
            subslot    <= '0;
            slot       <= SLOT0;
            slot_idx   <= '0;
            ch         <= '0;
            op         <= 1'b0;
            frame      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (cen) begin
                group    <= grp_nx;
                subslot  <= sub_nx;
                slot     <= slot_nx;
                slot_idx <= idx_nx;
                ch       <= ch_nx;
                op       <= op_nx;
                if (wrap) begin
                    frame      <= frame + 1'b1;
                    frame_tick <= 1'b1;
                end
            end
        end
    end

    assign zero = slot[0];
    assign last = slot[NSLOT-1];

endmodule

// File: tb/tb_jtopl_slot_seq.sv
// Directed bench for jtopl_slot_seq: four parameterisations driven in lockstep,
// checked against a frame-position model plus hand-computed vectors.
module tb_jtopl_slot_seq;
    import jtopl_pkg::*;

    localparam int NI = 4;
    localparam int GA [NI] = '{3, 6, 3, 1};
    localparam int SA [NI] = '{6, 6, 6, 2};
    localparam int FA [NI] = '{4, 4, 2, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    always #5 clk = ~clk;

    logic [63:0] o_slot  [NI];
    logic [63:0] o_idx   [NI];
    logic [63:0] o_grp   [NI];
    logic [63:0] o_sub   [NI];
    logic [63:0] o_ch    [NI];
    logic [63:0] o_frame [NI];
    logic        o_op    [NI];
    logic        o_tick  [NI];
    logic        o_zero  [NI];
    logic        o_last  [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int G = GA[gi];
        localparam int S = SA[gi];
        localparam int F = FA[gi];
        localparam int N = G * S;

        logic                       zero, last, op, tick;
        logic [gw_of(G)-1:0]        group;
        logic [sw_of(S)-1:0]        subslot;
        logic [N-1:0]               slot;
        logic [iw_of(G, S)-1:0]     slot_idx;
        logic [cw_of(G, S)-1:0]     ch;
        logic [F-1:0]               frame;

        jtopl_slot_seq #(
            .GROUPS   (G),
            .SUBSLOTS (S),
            .FRAME_W  (F)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cen        (cen),
            .zero       (zero),
            .last       (last),
            .group      (group),
            .subslot    (subslot),
            .op         (op),
            .slot       (slot),
            .slot_idx   (slot_idx),
            .ch         (ch),
            .frame      (frame),
            .frame_tick (tick)
        );

        assign o_slot[gi]  = 64'(slot);
        assign o_idx[gi]   = 64'(slot_idx);
        assign o_grp[gi]   = 64'(group);
        assign o_sub[gi]   = 64'(subslot);
        assign o_ch[gi]    = 64'(ch);
        assign o_frame[gi] = 64'(frame);
        assign o_op[gi]    = op;
        assign o_tick[gi]  = tick;
        assign o_zero[gi]  = zero;
        assign o_last[gi]  = last;
    end

    int n_chk  = 0;
    int n_pass = 0;

    int m_idx   [NI];
    int m_frame [NI];
    bit m_tick  [NI];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int n, s, h, idx, sub, grp;
            n   = GA[i] * SA[i];
            s   = SA[i];
            h   = s / 2;
            idx = m_idx[i];
            sub = idx % s;
            grp = idx / s;
            chk($sformatf("i%0d slot_idx", i), o_idx[i], 64'(idx));
            chk($sformatf("i%0d slot", i), o_slot[i], 64'(1) << idx);
            chk($sformatf("i%0d group", i), o_grp[i], 64'(grp));
            chk($sformatf("i%0d subslot", i), o_sub[i], 64'(sub));
            chk($sformatf("i%0d ch", i), o_ch[i], 64'(grp * h + sub % h));
            chk($sformatf("i%0d op", i), 64'(o_op[i]), 64'(sub >= h));
            chk($sformatf("i%0d frame", i), o_frame[i], 64'(m_frame[i]));
            chk($sformatf("i%0d tick", i), 64'(o_tick[i]), 64'(m_tick[i]));
            chk($sformatf("i%0d zero", i), 64'(o_zero[i]), 64'(idx == 0));
            chk($sformatf("i%0d last", i), 64'(o_last[i]), 64'(idx == n - 1));
        end
    endtask

    task automatic step(input bit r, input bit c);
        rst = r;
        cen = c;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                m_idx[i]   = 0;
                m_frame[i] = 0;
                m_tick[i]  = 1'b0;
            end else begin
                m_tick[i] = 1'b0;
                if (c) begin
                    if (m_idx[i] == GA[i] * SA[i] - 1) begin
                        m_idx[i]   = 0;
                        m_frame[i] = (m_frame[i] + 1) % (1 << FA[i]);
                        m_tick[i]  = 1'b1;
                    end else begin
                        m_idx[i]++;
                    end
                end
            end
        end
        #1;
        check_all();
    endtask

    typedef struct {
        bit rst;
        bit cen;
        int idx;
        int frame;
        bit tick;
    } vec_t;

    vec_t tv [11];
    int   chx [13];
    int   ticks, mx_g, mx_c;

    initial begin
        tv[0]  = '{1, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 1, 0, 0};
        tv[2]  = '{0, 0, 1, 0, 0};
        tv[3]  = '{0, 1, 2, 0, 0};
        tv[4]  = '{0, 1, 3, 0, 0};
        tv[5]  = '{0, 0, 3, 0, 0};
        tv[6]  = '{1, 1, 0, 0, 0};
        tv[7]  = '{0, 1, 1, 0, 0};
        tv[8]  = '{1, 0, 0, 0, 0};
        tv[9]  = '{0, 0, 0, 0, 0};
        tv[10] = '{0, 1, 1, 0, 0};
        chx = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6};

        for (int i = 0; i < NI; i++) begin
            m_idx[i]   = 0;
            m_frame[i] = 0;
            m_tick[i]  = 1'b0;
        end

        for (int j = 0; j < 11; j++) begin
            step(tv[j].rst, tv[j].cen);
            chk($sformatf("vec%0d idx", j), o_idx[0], 64'(tv[j].idx));
            chk($sformatf("vec%0d frame", j), o_frame[0], 64'(tv[j].frame));
            chk($sformatf("vec%0d tick", j), 64'(o_tick[0]), 64'(tv[j].tick));
        end

        // Free-running 40 cycles.
        step(1, 0);
        chk("run ch0", o_ch[0], 64'(chx[0]));
        mx_g = 0;
        mx_c = 0;
        for (int k = 1; k <= 40; k++) begin
            step(0, 1);
            chk($sformatf("run idx k%0d", k), o_idx[0], 64'(k % 18));
            if (k < 13) chk($sformatf("run ch k%0d", k), o_ch[0], 64'(chx[k]));
            chk($sformatf("run tick k%0d", k), 64'(o_tick[0]),
                64'(k == 18 || k == 36));
            if (int'(o_grp[1]) > mx_g) mx_g = int'(o_grp[1]);
            if (int'(o_ch[1]) > mx_c) mx_c = int'(o_ch[1]);
        end
        chk("run frame", o_frame[0], 64'(2));
        chk("big group max", 64'(mx_g), 64'(5));
        chk("big ch max", 64'(mx_c), 64'(17));
        chk("big frame", o_frame[1], 64'(1));

        // cen every third cycle.
        step(1, 0);
        ticks = 0;
        for (int k = 1; k <= 54; k++) begin
            step(0, (k % 3) == 0);
            if (o_tick[0]) ticks++;
        end
        chk("sparse ticks", 64'(ticks), 64'(1));
        chk("sparse frame", o_frame[0], 64'(1));

        // Mid-frame reset with cen high, then with cen low.
        step(1, 0);
        for (int k = 0; k < 11; k++) step(0, 1);
        chk("pre-rst idx", o_idx[0], 64'(11));
        step(1, 1);
        chk("rst cen1 idx", o_idx[0], 64'(0));
        chk("rst cen1 slot", o_slot[0], 64'(1));
        chk("rst cen1 zero", 64'(o_zero[0]), 64'(1));
        chk("rst cen1 frame", o_frame[0], 64'(0));
        for (int k = 0; k < 11; k++) step(0, 1);
        step(1, 0);
        chk("rst cen0 idx", o_idx[0], 64'(0));
        chk("rst cen0 slot", o_slot[0], 64'(1));
        chk("rst cen0 zero", 64'(o_zero[0]), 64'(1));

        // Reset on the last slot must not count a frame.
        for (int k = 0; k < 17; k++) step(0, 1);
        chk("pre-wrap idx", o_idx[0], 64'(17));
        step(1, 1);
        chk("rst wrap frame", o_frame[0], 64'(0));
        chk("rst wrap tick", 64'(o_tick[0]), 64'(0));

        // FRAME_W=2 wraps 3 -> 0 after four frames.
        step(1, 0);
        for (int k = 1; k <= 72; k++) begin
            step(0, 1);
            if (k % 18 == 0) begin
                chk($sformatf("fw2 frame k%0d", k), o_frame[2],
                    64'((k / 18) % 4));
                chk($sformatf("fw2 tick k%0d", k), 64'(o_tick[2]), 64'(1));
            end
        end
        chk("fw2 wrapped", o_frame[2], 64'(0));

        // GROUPS=1, SUBSLOTS=2 alternates.
        step(1, 0);
        step(0, 1);
        chk("g1 slot a", o_slot[3], 64'(2));
        chk("g1 last a", 64'(o_last[3]), 64'(1));
        chk("g1 tick a", 64'(o_tick[3]), 64'(0));
        step(0, 1);
        chk("g1 slot b", o_slot[3], 64'(1));
        chk("g1 zero b", 64'(o_zero[3]), 64'(1));
        chk("g1 tick b", 64'(o_tick[3]), 64'(1));
        chk("g1 frame b", o_frame[3], 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
